// File: rtl/sisc_pkg.sv
// Shared SISC definitions: fetch FSM encoding, datapath widths and instruction field positions.
package sisc_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 32;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 28;
   localparam int MM_HI  = 27;
   localparam int MM_LO  = 24;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: synchronous clear, sequential increment and branch-target load.
module pc_reg
   import sisc_pkg::*;
(
   input  logic            clk,
   input  logic            rst_f,
   input  logic            pc_rst,
   input  logic            pc_write,
   input  logic            pc_sel,
   input  logic            br_sel,
   input  logic [PC_W-1:0] imm,
   output logic [PC_W-1:0] pc
);

   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] cur);
      return cur + PC_W'(1);
   endfunction

   // Relative targets wrap modulo 2^PC_W; absolute targets take the immediate as-is.
   function automatic logic [PC_W-1:0] br_target(input logic [PC_W-1:0] cur,
                                                  input logic [PC_W-1:0] off,
                                                  input logic            absolute);
      return absolute ? off : cur + off;
   endfunction

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_nxt;

   always_comb begin
      pc_nxt = pc_q;
      if (pc_rst)
         pc_nxt = '0;
      else if (pc_write)
         pc_nxt = pc_sel ? br_target(pc_q, imm, br_sel) : pc_inc(pc_q);
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f)
         pc_q <= '0;
      else
         pc_q <= pc_nxt;
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM, instruction register and PC. Optional prefetch buffer
// is enabled by defining FETCH_PREFETCH_EN.
module fetch_unit
   import sisc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_f,
   input  logic               ir_load,
   input  logic               pc_rst,
   input  logic               pc_write,
   input  logic               pc_sel,
   input  logic               br_sel,
   output logic               im_req,
   output logic [PC_W-1:0]    im_addr,
   input  logic               im_ack,
   input  logic [INSTR_W-1:0] im_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [PC_W-1:0]    pc,
   output logic               ir_valid,
   output logic               fetch_busy
);

   fetch_state_t       state_q, state_nxt;
   logic               im_req_q, im_req_nxt;
   logic [PC_W-1:0]    im_addr_q, im_addr_nxt;
   logic [INSTR_W-1:0] ir_q, ir_nxt;
   logic               ir_valid_q, ir_valid_nxt;

`ifdef FETCH_PREFETCH_EN
   logic [INSTR_W-1:0] pf_data_q, pf_data_nxt;
   logic [PC_W-1:0]    pf_addr_q, pf_addr_nxt;
   logic               pf_valid_q, pf_valid_nxt;
   logic               pf_pend_q, pf_pend_nxt;   // a completed fetch still owes a prefetch
   logic               pf_fly_q, pf_fly_nxt;     // outstanding request belongs to the buffer
   logic               pf_inv;
   logic               pf_hit;
`endif

   pc_reg u_pc_reg (
      .clk      (clk),
      .rst_f    (rst_f),
      .pc_rst   (pc_rst),
      .pc_write (pc_write),
      .pc_sel   (pc_sel),
      .br_sel   (br_sel),
      .imm      (ir_q[IMM_HI:IMM_LO]),
      .pc       (pc)
   );

   always_comb begin
      state_nxt    = state_q;
      im_req_nxt   = im_req_q;
      im_addr_nxt  = im_addr_q;
      ir_nxt       = ir_q;
      ir_valid_nxt = ir_valid_q;
`ifdef FETCH_PREFETCH_EN
      pf_data_nxt  = pf_data_q;
      pf_addr_nxt  = pf_addr_q;
      pf_valid_nxt = pf_valid_q;
      pf_pend_nxt  = pf_pend_q;
      pf_fly_nxt   = pf_fly_q;
      pf_inv       = pc_rst | (pc_write & pc_sel);
      pf_hit       = pf_valid_q && (pf_addr_q == pc);
      if (pf_inv)
         pf_valid_nxt = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef FETCH_PREFETCH_EN
            if (ir_load && pf_hit) begin
               ir_nxt       = pf_data_q;
               ir_valid_nxt = 1'b1;
               pf_valid_nxt = 1'b0;
               pf_pend_nxt  = 1'b1;
            end else if (ir_load) begin
               state_nxt    = ST_REQ;
               im_req_nxt   = 1'b1;
               im_addr_nxt  = pc;
               ir_valid_nxt = 1'b0;
               pf_valid_nxt = 1'b0;
               pf_pend_nxt  = 1'b0;
               pf_fly_nxt   = 1'b0;
            end else if (pf_pend_q && !pf_valid_q && !pc_rst && !pc_write) begin
               // Only issue on a quiet PC so the buffered address matches the next ir_load.
               state_nxt   = ST_REQ;
               im_req_nxt  = 1'b1;
               im_addr_nxt = pc;
               pf_pend_nxt = 1'b0;
               pf_fly_nxt  = 1'b1;
            end
`else
            if (ir_load) begin
               state_nxt    = ST_REQ;
               im_req_nxt   = 1'b1;
               im_addr_nxt  = pc;
               ir_valid_nxt = 1'b0;
            end
`endif
         end

         ST_REQ: begin
`ifdef FETCH_PREFETCH_EN
            if (pc_rst || (pf_fly_q && pf_inv)) begin
`else
            if (pc_rst) begin
`endif
               // An ack in the same cycle ends the request; otherwise wait it out in DRAIN.
               if (im_ack) begin
                  state_nxt  = ST_IDLE;
                  im_req_nxt = 1'b0;
               end else begin
                  state_nxt  = ST_DRAIN;
               end
            end else if (im_ack) begin
               state_nxt  = ST_IDLE;
               im_req_nxt = 1'b0;
`ifdef FETCH_PREFETCH_EN
               if (pf_fly_q) begin
                  pf_data_nxt  = im_rdata;
                  pf_addr_nxt  = im_addr_q;
                  pf_valid_nxt = 1'b1;
               end else begin
                  ir_nxt       = im_rdata;
                  ir_valid_nxt = 1'b1;
                  pf_pend_nxt  = 1'b1;
               end
`else
               ir_nxt       = im_rdata;
               ir_valid_nxt = 1'b1;
`endif
            end
         end

         ST_DRAIN: begin
            if (im_ack) begin
               state_nxt  = ST_IDLE;
               im_req_nxt = 1'b0;
            end
         end

         default: begin
            state_nxt  = ST_IDLE;
            im_req_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q    <= ST_IDLE;
         im_req_q   <= 1'b0;
         im_addr_q  <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
         pf_data_q  <= '0;
         pf_addr_q  <= '0;
         pf_valid_q <= 1'b0;
         pf_pend_q  <= 1'b0;
         pf_fly_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_nxt;
         im_req_q   <= im_req_nxt;
         im_addr_q  <= im_addr_nxt;
         ir_q       <= ir_nxt;
         ir_valid_q <= ir_valid_nxt;
`ifdef FETCH_PREFETCH_EN
         pf_data_q  <= pf_data_nxt;
         pf_addr_q  <= pf_addr_nxt;
         pf_valid_q <= pf_valid_nxt;
         pf_pend_q  <= pf_pend_nxt;
         pf_fly_q   <= pf_fly_nxt;
`endif
      end
   end

   assign im_req     = im_req_q;
   assign im_addr    = im_addr_q;
   assign instr      = ir_q;
   assign opcode     = ir_q[OPC_HI:OPC_LO];
   assign mm         = ir_q[MM_HI:MM_LO];
   assign ir_valid   = ir_valid_q;
   assign fetch_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: expected IR words go through a scoreboard queue; PC and FSM
// behaviour is checked against constants.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_f = 1'b0;
   logic        ir_load = 1'b0;
   logic        pc_rst = 1'b0;
   logic        pc_write = 1'b0;
   logic        pc_sel = 1'b0;
   logic        br_sel = 1'b0;
   logic        im_ack = 1'b0;
   logic [31:0] im_rdata = '0;
   logic        im_req;
   logic [15:0] im_addr;
   logic [31:0] instr;
   logic [3:0]  opcode;
   logic [3:0]  mm;
   logic [15:0] pc;
   logic        ir_valid;
   logic        fetch_busy;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];

   fetch_unit dut (
      .clk        (clk),
      .rst_f      (rst_f),
      .ir_load    (ir_load),
      .pc_rst     (pc_rst),
      .pc_write   (pc_write),
      .pc_sel     (pc_sel),
      .br_sel     (br_sel),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .im_ack     (im_ack),
      .im_rdata   (im_rdata),
      .instr      (instr),
      .opcode     (opcode),
      .mm         (mm),
      .pc         (pc),
      .ir_valid   (ir_valid),
      .fetch_busy (fetch_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pc_upd(input logic sel, input logic br);
      pc_write = 1'b1;
      pc_sel   = sel;
      br_sel   = br;
      step();
      pc_write = 1'b0;
      pc_sel   = 1'b0;
      br_sel   = 1'b0;
   endtask

   task automatic pop_instr(input string tag);
      if (exp_q.size() == 0)
         check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      else
         check(tag, instr, exp_q.pop_front());
   endtask

   // Full fetch: ir_load, hold request for wait_cyc cycles, ack with data.
   task automatic do_fetch(input logic [31:0] data, input logic [15:0] addr, input int wait_cyc);
      ir_load = 1'b1;
      step();
      ir_load = 1'b0;
      check("req_up", im_req, 1);
      check("busy_up", fetch_busy, 1);
      check("req_addr", im_addr, addr);
      check("ir_valid_clr", ir_valid, 0);
      repeat (wait_cyc - 1) step();
      check("req_hold", im_req, 1);
      check("addr_hold", im_addr, addr);
      im_ack   = 1'b1;
      im_rdata = data;
      exp_q.push_back(data);
      step();
      im_ack   = 1'b0;
      im_rdata = '0;
      check("ir_valid_set", ir_valid, 1);
      pop_instr("instr");
      check("req_drop", im_req, 0);
      check("busy_drop", fetch_busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_f = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", pc, 0);
      check("rst_instr", instr, 0);
      check("rst_ir_valid", ir_valid, 0);
      check("rst_im_req", im_req, 0);
      check("rst_im_addr", im_addr, 0);
      check("rst_busy", fetch_busy, 0);
      rst_f = 1'b1;
      step();

`ifndef FETCH_PREFETCH_EN
      do_fetch(32'h1234_0005, 16'h0000, 3);
      check("opcode", opcode, 4'h1);
      check("mm", mm, 4'h2);

      // Load IR imm=0x0010 and jump there absolutely, then exercise the branch modes.
      do_fetch(32'h0000_0010, 16'h0000, 1);
      pc_upd(1'b1, 1'b1);
      check("pc_abs_10", pc, 16'h0010);
      do_fetch(32'h7700_FFFE, 16'h0010, 2);
      pc_upd(1'b1, 1'b0);
      check("pc_rel", pc, 16'h000E);
      pc_upd(1'b1, 1'b1);
      check("pc_abs", pc, 16'hFFFE);
      pc_upd(1'b0, 1'b0);
      check("pc_inc", pc, 16'hFFFF);
      pc_upd(1'b0, 1'b0);
      check("pc_wrap", pc, 16'h0000);

      // Fetch and PC update in the same IDLE cycle, then another PC update mid-REQ.
      ir_load  = 1'b1;
      pc_write = 1'b1;
      step();
      ir_load  = 1'b0;
      check("pre_upd_addr", im_addr, 16'h0000);
      check("pre_upd_pc", pc, 16'h0001);
      step();
      pc_write = 1'b0;
      check("req_addr_kept", im_addr, 16'h0000);
      check("req_pc", pc, 16'h0002);
      im_ack   = 1'b1;
      im_rdata = 32'hA5A5_0003;
      exp_q.push_back(32'hA5A5_0003);
      step();
      im_ack   = 1'b0;
      check("ir_valid_2", ir_valid, 1);
      pop_instr("instr_2");

      // Stray ack in IDLE.
      im_ack   = 1'b1;
      im_rdata = 32'hFFFF_FFFF;
      step();
      im_ack   = 1'b0;
      check("idle_ack_instr", instr, 32'hA5A5_0003);
      check("idle_ack_req", im_req, 0);
      check("idle_ack_busy", fetch_busy, 0);

      // pc_rst mid-REQ: drain and discard.
      ir_load = 1'b1;
      step();
      ir_load = 1'b0;
      check("drain_addr", im_addr, 16'h0002);
      pc_rst = 1'b1;
      step();
      pc_rst = 1'b0;
      check("drain_busy", fetch_busy, 1);
      check("drain_req", im_req, 1);
      check("drain_pc", pc, 0);
      check("drain_ir_valid", ir_valid, 0);
      im_ack   = 1'b1;
      im_rdata = 32'hDEAD_BEEF;
      step();
      im_ack   = 1'b0;
      check("drain_instr", instr, 32'hA5A5_0003);
      check("drain_ir_valid_post", ir_valid, 0);
      check("drain_idle", fetch_busy, 0);
      check("drain_req_drop", im_req, 0);
      check("drain_sb_empty", 32'(exp_q.size()), 0);

      // Asynchronous reset in the middle of a request.
      pc_upd(1'b0, 1'b0);
      ir_load = 1'b1;
      step();
      ir_load = 1'b0;
      check("arst_req_before", im_req, 1);
      #2 rst_f = 1'b0;
      #1;
      check("arst_req", im_req, 0);
      check("arst_busy", fetch_busy, 0);
      check("arst_pc", pc, 0);
      check("arst_instr", instr, 0);
      check("arst_addr", im_addr, 0);
      #2 rst_f = 1'b1;
      step();
      check("arst_post_busy", fetch_busy, 0);
      check("arst_post_req", im_req, 0);
`else
      repeat (4) pc_upd(1'b0, 1'b0);
      check("pf_pc4", pc, 16'h0004);
      ir_load = 1'b1;
      step();
      ir_load = 1'b0;
      check("pf_addr4", im_addr, 16'h0004);
      pc_write = 1'b1;
      step();
      pc_write = 1'b0;
      check("pf_pc5", pc, 16'h0005);
      im_ack   = 1'b1;
      im_rdata = 32'h1100_0004;
      exp_q.push_back(32'h1100_0004);
      step();
      im_ack   = 1'b0;
      check("pf_ir_valid4", ir_valid, 1);
      pop_instr("pf_instr4");
      step();
      check("pf_req", im_req, 1);
      check("pf_req_addr", im_addr, 16'h0005);
      im_ack   = 1'b1;
      im_rdata = 32'h2200_0005;
      step();
      im_ack   = 1'b0;
      check("pf_fill_req_drop", im_req, 0);
      check("pf_fill_instr", instr, 32'h1100_0004);
      ir_load = 1'b1;
      exp_q.push_back(32'h2200_0005);
      step();
      ir_load = 1'b0;
      check("pf_hit_no_req", im_req, 0);
      check("pf_hit_busy", fetch_busy, 0);
      check("pf_hit_valid", ir_valid, 1);
      pop_instr("pf_hit_instr");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
